// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the fetch path: PC width, instruction
// word width, instruction memory depth, reset values and the PC-source decode.
package cpu_pkg;

    localparam int PC_W      = 8;
    localparam int WORD_W    = 16;
    localparam int MEM_DEPTH = 256;

    localparam logic [PC_W-1:0]   PC_RST = '0;
    localparam logic [PC_W-1:0]   PC_MAX = '1;
    localparam logic [PC_W-1:0]   PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [WORD_W-1:0] IR_RST = '0;

    // Where the next PC (and the next memory read address) comes from,
    // listed in priority order.
    typedef enum logic [2:0] {
        PC_SRC_RESET = 3'd0,
        PC_SRC_CLR   = 3'd1,
        PC_SRC_LD    = 3'd2,
        PC_SRC_INC   = 3'd3,
        PC_SRC_HOLD  = 3'd4
    } pc_src_e;

    // Increment modulo 2**PC_W.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_ONE;
    endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: MEM_DEPTH x WORD_W, one synchronous write port and one
// synchronous read port with a registered output. A read and a write to the
// same address on the same edge return the old word (read-before-write).
// Contents are deliberately not reset.
module instr_mem
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [PC_W-1:0]   wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [PC_W-1:0]   rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem_q [MEM_DEPTH];
    logic [WORD_W-1:0] rd_data_q;

    // Array write and registered read share one edge; the non-blocking
    // read samples the pre-write contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: program counter, instruction register and sticky
// PC wrap flag in front of a synchronous instruction memory. The memory is
// addressed with the *next* PC so that its registered output always holds
// the word at the current PC.
// Optional feature: define FETCH_JMP_EN to add the PC_LD / PC_TARGET
// jump-target load ports; without it PC_LD is treated as 0.
module fetch_unit
    import cpu_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              PC_CLR,
    input  logic              PC_IC,
    input  logic              IR_LD,
    input  logic              PROG_WE,
    input  logic [PC_W-1:0]   PROG_ADDR,
    input  logic [WORD_W-1:0] PROG_DATA,
    output logic [WORD_W-1:0] IR,
    output logic [PC_W-1:0]   PC,
    output logic              PC_WRAP
`ifdef FETCH_JMP_EN
    ,
    input  logic              PC_LD,
    input  logic [PC_W-1:0]   PC_TARGET
`endif
);

    logic              pc_ld;
    logic [PC_W-1:0]   pc_target;

`ifdef FETCH_JMP_EN
    assign pc_ld     = PC_LD;
    assign pc_target = PC_TARGET;
`else
    assign pc_ld     = 1'b0;
    assign pc_target = PC_RST;
`endif

    pc_src_e           pc_src;
    logic [PC_W-1:0]   na;
    logic [PC_W-1:0]   pc_d,      pc_q;
    logic [WORD_W-1:0] ir_d,      ir_q;
    logic              pc_wrap_d, pc_wrap_q;
    logic [WORD_W-1:0] mem_q;

    // Pick the PC source by priority Reset > PC_CLR > PC_LD > PC_IC > hold.
    always_comb begin
        pc_src = PC_SRC_HOLD;
        if (Reset) begin
            pc_src = PC_SRC_RESET;
        end else if (PC_CLR) begin
            pc_src = PC_SRC_CLR;
        end else if (pc_ld) begin
            pc_src = PC_SRC_LD;
        end else if (PC_IC) begin
            pc_src = PC_SRC_INC;
        end
    end

    // Next PC doubles as the memory read address; wrap is sticky and only
    // set by a plain increment out of the top address.
    always_comb begin
        na        = pc_q;
        pc_wrap_d = pc_wrap_q;
        case (pc_src)
            PC_SRC_RESET: begin
                na        = PC_RST;
                pc_wrap_d = 1'b0;
            end
            PC_SRC_CLR:   na = PC_RST;
            PC_SRC_LD:    na = pc_target;
            PC_SRC_INC: begin
                na = pc_inc(pc_q);
                if (pc_q == PC_MAX) begin
                    pc_wrap_d = 1'b1;
                end
            end
            default:      na = pc_q;
        endcase
        pc_d = na;
    end

    // IR captures the memory output, which is the word at the pre-update PC.
    always_comb begin
        ir_d = ir_q;
        if (IR_LD) begin
            ir_d = mem_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_q      <= PC_RST;
            ir_q      <= IR_RST;
            pc_wrap_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            pc_wrap_q <= pc_wrap_d;
        end
    end

    instr_mem u_instr_mem (
        .clk     (Clock),
        .wr_en   (PROG_WE),
        .wr_addr (PROG_ADDR),
        .wr_data (PROG_DATA),
        .rd_addr (na),
        .rd_data (mem_q)
    );

    assign IR      = ir_q;
    assign PC      = pc_q;
    assign PC_WRAP = pc_wrap_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random commands, all
// checked against a cycle-level behavioural model of the fetch rules.
module tb_fetch_unit;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        PC_CLR = 1'b0;
    logic        PC_IC = 1'b0;
    logic        IR_LD = 1'b0;
    logic        PROG_WE = 1'b0;
    logic [7:0]  PROG_ADDR = '0;
    logic [15:0] PROG_DATA = '0;
    logic [15:0] IR;
    logic [7:0]  PC;
    logic        PC_WRAP;
    logic        PC_LD = 1'b0;
    logic [7:0]  PC_TARGET = '0;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    logic [15:0] mem_m [256];
    logic [7:0]  pc_m   = '0;
    logic [15:0] ir_m   = '0;
    logic [15:0] word_m = '0;   // word fetched at the current PC
    logic        wrap_m = 1'b0;

    // Clock.
    always #5 Clock = ~Clock;

    fetch_unit dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .PC_CLR    (PC_CLR),
        .PC_IC     (PC_IC),
        .IR_LD     (IR_LD),
        .PROG_WE   (PROG_WE),
        .PROG_ADDR (PROG_ADDR),
        .PROG_DATA (PROG_DATA),
        .IR        (IR),
        .PC        (PC),
        .PC_WRAP   (PC_WRAP)
`ifdef FETCH_JMP_EN
        ,
        .PC_LD     (PC_LD),
        .PC_TARGET (PC_TARGET)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model, then compare all outputs.
    task automatic drive(input bit rst, input bit clr, input bit ic, input bit irld,
                         input bit we, input logic [7:0] addr, input logic [15:0] data,
                         input bit ld, input logic [7:0] tgt);
        int next_pc;
        Reset = rst; PC_CLR = clr; PC_IC = ic; IR_LD = irld;
        PROG_WE = we; PROG_ADDR = addr; PROG_DATA = data;
        PC_LD = ld; PC_TARGET = tgt;
`ifndef FETCH_JMP_EN
        ld = 1'b0;
`endif
        if (rst || clr)  next_pc = 0;
        else if (ld)     next_pc = int'(tgt);
        else if (ic)     next_pc = (int'(pc_m) + 1) % 256;
        else             next_pc = int'(pc_m);
        if (rst)                                 wrap_m = 1'b0;
        else if (!clr && !ld && ic && pc_m == 8'd255) wrap_m = 1'b1;
        if (rst)       ir_m = 16'h0000;
        else if (irld) ir_m = word_m;
        word_m = mem_m[next_pc];
        if (we) mem_m[addr] = data;
        pc_m = 8'(next_pc);
        @(posedge Clock);
        #1;
        chk("pc", {8'h00, PC}, {8'h00, pc_m});
        chk("ir", IR, ir_m);
        chk("wrap", {15'h0, PC_WRAP}, {15'h0, wrap_m});
    endtask

    task automatic step(input bit rst, input bit clr, input bit ic, input bit irld);
        drive(rst, clr, ic, irld, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
    endtask

    initial begin
        logic [15:0] d;
        logic [15:0] old5;
        int guard;
        for (int i = 0; i < 256; i++) mem_m[i] = 16'h0000;

        // Program the whole memory while held in reset.
        for (int a = 0; a < 256; a++) begin
            case (a)
                0:       d = 16'h1234;
                1:       d = 16'h2345;
                2:       d = 16'h3456;
                5:       d = 16'h5555;
                default: d = 16'($urandom);
            endcase
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'(a), d, 1'b0, 8'h00);
        end
        chk("reset_pc", {8'h00, PC}, 16'h0000);
        chk("reset_ir", IR, 16'h0000);

        // Fetch first two words.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ir_1234", IR, 16'h1234);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ir_2345", IR, 16'h2345);
        chk("pc_01", {8'h00, PC}, 16'h0001);

        // IR_LD with PC_IC loads the pre-increment word.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("ir_same_cycle", IR, 16'h2345);
        chk("pc_02", {8'h00, PC}, 16'h0002);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ir_3456", IR, 16'h3456);

        // Walk to 0xFF and wrap.
        guard = 0;
        while (pc_m != 8'hFF && guard < 300) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            guard++;
        end
        chk("reach_ff", {8'h00, PC}, 16'h00FF);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("wrap_pc", {8'h00, PC}, 16'h0000);
        chk("wrap_set", {15'h0, PC_WRAP}, 16'h0001);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("wrap_sticky", {15'h0, PC_WRAP}, 16'h0001);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("wrap_reset", {15'h0, PC_WRAP}, 16'h0000);

        // Write to the address being fetched: old word first, new word later.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pc_04", {8'h00, PC}, 16'h0004);
        old5 = mem_m[5];
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 16'hBEEF, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rbw_old", IR, old5);
        chk("rbw_old_const", IR, 16'h5555);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ir_beef", IR, 16'hBEEF);

        // Reset overrides PC_IC and IR_LD mid-operation.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pc_10", {8'h00, PC}, 16'h0010);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("rst_pc", {8'h00, PC}, 16'h0000);
        chk("rst_ir", IR, 16'h0000);
        chk("rst_wrap", {15'h0, PC_WRAP}, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ir_after_rst", IR, 16'h1234);

`ifdef FETCH_JMP_EN
        // Jump-target load beats increment; clear beats jump.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h40);
        chk("jmp_pc", {8'h00, PC}, 16'h0040);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("jmp_ir", IR, mem_m[8'h40]);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h77);
        chk("clr_over_jmp", {8'h00, PC}, 16'h0000);
`endif

        // Random command mix.
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 31) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0,
                  8'($urandom), 16'($urandom),
                  $urandom_range(0, 7) == 0,
                  8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have Clock  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have Reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have PC_CLR  input  1  clear program counter (PC) command from the control unit.
REQ-004 SHALL have PC_IC  input  1  increment PC command.
REQ-005 SHALL have IR_LD  input  1  load instruction register (IR) command.
REQ-006 SHALL have PROG_WE  input  1  program-load write enable.
REQ-007 SHALL have PROG_ADDR  input  8  program-load word address.
REQ-008 SHALL have PROG_DATA  input  16  program-load word.
REQ-009 SHALL have IR  output  16  current instruction to the control unit.
REQ-010 SHALL have PC  output  8  current program counter.
REQ-011 SHALL have PC_WRAP  output  1  sticky flag: PC incremented past 0xFF.

Function
REQ-012 SHALL hold a 256x16 instruction memory with one synchronous read port (registered output MEM_Q, 1-cycle latency) and one synchronous write port.
REQ-013 SHALL compute read address NA = 0 if Reset or PC_CLR, else PC_TARGET if PC_LD (macro), else PC+1 (mod 256) if PC_IC, else PC; MEM_Q and PC SHALL update on the same edge, so MEM_Q == mem[PC] every cycle after the first post-reset cycle.
REQ-014 SHALL update PC at each edge with priority Reset > PC_CLR > PC_LD > PC_IC > hold.
REQ-015 SHALL load IR <= MEM_Q when IR_LD=1, else hold; IR_LD with PC_IC/PC_CLR in the same cycle loads the word for the pre-update PC.
REQ-016 SHALL set PC_WRAP when PC_IC increments from 0xFF to 0x00 (PC_CLR/PC_LD not asserted); cleared only by Reset.
REQ-017 SHALL write mem[PROG_ADDR] <= PROG_DATA on PROG_WE; if PROG_ADDR == NA, MEM_Q SHALL return the old word (read-before-write).
REQ-018 SHALL give IR_LD no effect on PC; all outputs registered, no combinational input-to-output paths.

Reset
REQ-019 SHALL on Reset force PC=0x00, IR=0x0000, PC_WRAP=0, and present NA=0 so MEM_Q == mem[0] the cycle after Reset deasserts.
REQ-020 SHALL not clear memory contents on Reset; PROG_WE SHALL be honoured during Reset.
REQ-021 SHALL let Reset mid-operation override any simultaneous PC_CLR/PC_IC/IR_LD/PC_LD.

Configuration
REQ-022 SHALL compile inputs PC_LD (1) and PC_TARGET (8), jump-target load, only when macro FETCH_JMP_EN is defined; PC_LD SHALL set PC <= PC_TARGET and PC_WRAP SHALL be unaffected.
REQ-023 SHALL, without FETCH_JMP_EN, omit both ports and treat PC_LD as 0.

Structure
REQ-024 SHALL place PC width (8), word width (16), memory depth (256), and reset constants in shared package cpu_pkg.
REQ-025 SHALL implement the memory as sub-module instr_mem (sync read with registered output, sync write, read-before-write); PC, NA, IR and PC_WRAP logic in fetch_unit.

Verification
REQ-026 SHALL cover: load mem[0..2]=0x1234,0x2345,0x3456, Reset, then PC_CLR; IR_LD -> IR=0x1234; PC_IC; IR_LD -> IR=0x2345, PC=0x01.
REQ-027 SHALL cover: same-cycle IR_LD+PC_IC at PC=0x01 -> IR=0x2345, PC=0x02; next IR_LD -> IR=0x3456.
REQ-028 SHALL cover: PC=0xFF, PC_IC -> PC=0x00, PC_WRAP=1; PC_CLR -> PC_WRAP stays 1; Reset -> 0.
REQ-029 SHALL cover: PROG_WE to address NA=0x05 with 0xBEEF while PC_IC from 0x04 -> MEM_Q old word; PC_CLR, then PC_IC x5 and IR_LD -> IR=0xBEEF.
REQ-030 SHALL cover: Reset asserted with PC_IC+IR_LD at PC=0x10 -> PC=0x00, IR=0x0000, PC_WRAP=0.
REQ-031 SHALL cover (FETCH_JMP_EN): PC_LD+PC_IC, PC_TARGET=0x40 -> PC=0x40; next IR_LD -> IR=mem[0x40]; PC_CLR+PC_LD -> PC=0x00.
